// File: rtl/smvm_rom_pkg.sv
// Shared types for the coefficient ROM read sequencer: default widths,
// sequencer states and the output beat record.
package smvm_rom_pkg;

    localparam int DEFAULT_ADDR_W = 7;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One output beat: {odd entry, even entry}, byte keep mask, end-of-command mark.
    typedef struct packed {
        logic [2*DEFAULT_DATA_W-1:0] data;
        logic [1:0]                  keep;
        logic                        last;
    } beat_t;

endpackage

// File: rtl/rom_pair_streamer_if.sv
// Bus bundle between the pair streamer, the dual-port ROM and the downstream sink.
interface rom_pair_streamer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0]   rom_addr_a;
    logic [ADDR_W-1:0]   rom_addr_b;
    logic [DATA_W-1:0]   rom_q_a;
    logic [DATA_W-1:0]   rom_q_b;
    logic                out_valid;
    logic                out_ready;
    logic [2*DATA_W-1:0] out_data;
    logic [1:0]          out_keep;
    logic                out_last;

    modport master (
        output rom_addr_a, rom_addr_b, out_valid, out_data, out_keep, out_last,
        input  rom_q_a, rom_q_b, out_ready
    );

    modport slave (
        input  rom_addr_a, rom_addr_b, out_valid, out_data, out_keep, out_last,
        output rom_q_a, rom_q_b, out_ready
    );

endinterface

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO of output beats; occupancy feeds the issue credit check.
module rom_rd_fifo
    import smvm_rom_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             wr_en,
    input  beat_t            wr_beat,
    input  logic             rd_en,
    output beat_t            head,
    output logic             not_empty,
    output logic [OCC_W-1:0] occupancy
);

    beat_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign not_empty = (occupancy != '0);
    assign pop       = rd_en && not_empty;
    assign head      = mem[rd_ptr];

    // Storage is cleared on reset so the idle head presents all-zero outputs.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_beat;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({wr_en, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: rtl/rom_pair_streamer.sv
// Walks a wrap-around ROM address range two entries per cycle and streams the
// read data as 16-bit beats, issuing reads only when buffer space is guaranteed.
module rom_pair_streamer
    import smvm_rom_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    rom_pair_streamer_if.master bus
);

    localparam int            OCC_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_a, addr_b;
    logic [ADDR_W-1:0]  pairs_left;
    logic               odd_cmd;
    logic               zero_done;
    logic [RD_LAT-1:0]  pipe_v, pipe_last, pipe_odd;
    logic [ADDR_W:0]    count_clamped;
    logic               accept, zero_cmd, issue_fire, final_pair, pop;
    logic [DATA_W-1:0]  cap_hi;
    int                 in_flight;
    beat_t              cap_beat, head;
    logic               not_empty;
    logic [OCC_W-1:0]   occupancy;

    assign count_clamped = (count > MAX_COUNT) ? MAX_COUNT : count;
    assign final_pair    = (pairs_left == ADDR_W'(1));
    assign pop           = not_empty && bus.out_ready;

    always_comb begin
        in_flight = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            in_flight += int'(pipe_v[i]);
        end
    end

    // The address registers are preloaded on accept, so an issue in ISSUE means the
    // pair currently on the ROM ports is sampled at the coming edge.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        zero_cmd   = 1'b0;
        issue_fire = 1'b0;
        done       = zero_done;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count_clamped != '0) begin
                        accept    = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        zero_cmd  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (in_flight + int'(occupancy) < FIFO_DEPTH) begin
                    issue_fire = 1'b1;
                    if (final_pair) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && head.last) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state      <= IDLE;
            addr_a     <= '0;
            addr_b     <= '0;
            pairs_left <= '0;
            odd_cmd    <= 1'b0;
            zero_done  <= 1'b0;
            pipe_v     <= '0;
            pipe_last  <= '0;
            pipe_odd   <= '0;
        end else begin
            state     <= state_nxt;
            zero_done <= zero_cmd;
            if (accept) begin
                addr_a     <= base;
                addr_b     <= base + 1'b1;
                pairs_left <= count_clamped[ADDR_W:1] + ADDR_W'(count_clamped[0]);
                odd_cmd    <= count_clamped[0];
            end else if (issue_fire && !final_pair) begin
                addr_a     <= addr_a + ADDR_W'(2);
                addr_b     <= addr_b + ADDR_W'(2);
                pairs_left <= pairs_left - 1'b1;
            end
            pipe_v[0]    <= issue_fire;
            pipe_last[0] <= final_pair;
            pipe_odd[0]  <= final_pair && odd_cmd;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_odd[i]  <= pipe_odd[i-1];
            end
        end
    end

    // The unused odd slot of an odd-length command is zeroed rather than passing stale ROM data.
    always_comb begin
        cap_hi        = pipe_odd[RD_LAT-1] ? '0 : bus.rom_q_b;
        cap_beat.data = {cap_hi, bus.rom_q_a};
        cap_beat.keep = pipe_odd[RD_LAT-1] ? 2'b01 : 2'b11;
        cap_beat.last = pipe_last[RD_LAT-1];
    end

    rom_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .wr_en     (pipe_v[RD_LAT-1]),
        .wr_beat   (cap_beat),
        .rd_en     (bus.out_ready),
        .head      (head),
        .not_empty (not_empty),
        .occupancy (occupancy)
    );

    assign busy           = (state != IDLE);
    assign bus.rom_addr_a = addr_a;
    assign bus.rom_addr_b = addr_b;
    assign bus.out_valid  = not_empty;
    assign bus.out_data   = head.data;
    assign bus.out_keep   = head.keep;
    assign bus.out_last   = head.last;

endmodule

// File: tb/tb_rom_pair_streamer.sv
// Scoreboard bench for rom_pair_streamer with a behavioural 2-cycle ROM (mem[i] = i+1).
module tb_rom_pair_streamer;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
    } exp_t;

    logic       clk;
    logic       rst_l;
    logic       start;
    logic [6:0] base;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int   checks;
    int   errors;
    int   done_cnt;
    exp_t sb [$];
    exp_t mon_e;
    logic [6:0] ra_q, rb_q;

    rom_pair_streamer_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    rom_pair_streamer #(
        .ADDR_W     (7),
        .DATA_W     (8),
        .RD_LAT     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .start (start),
        .base  (base),
        .count (count),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] romWord(input logic [6:0] a);
        return {1'b0, a} + 8'd1;
    endfunction

    // Registered address then registered output: data two edges after the address edge.
    always @(posedge clk) begin
        ra_q        <= bus.rom_addr_a;
        rb_q        <= bus.rom_addr_b;
        bus.rom_q_a <= romWord(ra_q);
        bus.rom_q_b <= romWord(rb_q);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushBeat(input logic [15:0] d, input logic [1:0] k, input logic l);
        sb.push_back('{data: d, keep: k, last: l});
    endtask

    task automatic applyStimulus(input logic [6:0] b, input logic [7:0] c);
        base  = b;
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, (n < budget), 1'b1);
    endtask

    // Monitor: compares every presented beat (stalled or not) against the queue head.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst_l && busy) begin
            checkOutput("credit_bound", ((dut.in_flight + int'(dut.occupancy)) <= 4), 1'b1);
        end
        if (rst_l && bus.out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_beat", {16'h0, bus.out_data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb[0];
                checkOutput("beat_data", bus.out_data, mon_e.data);
                checkOutput("beat_keep", bus.out_keep, mon_e.keep);
                checkOutput("beat_last", bus.out_last, mon_e.last);
                if (bus.out_ready) begin
                    checkOutput("done_on_last", done, mon_e.last);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        done_cnt      = 0;
        rst_l         = 1'b0;
        start         = 1'b0;
        base          = '0;
        count         = '0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checkOutput("rst_busy",  busy, 1'b0);
        checkOutput("rst_done",  done, 1'b0);
        checkOutput("rst_valid", bus.out_valid, 1'b0);
        checkOutput("rst_data",  bus.out_data, 16'h0);
        checkOutput("rst_addr",  {bus.rom_addr_b, bus.rom_addr_a}, 14'h0);
        tick();
        rst_l = 1'b1;
        repeat (2) tick();

        // base=0 count=8: four full beats, first valid after the 4th edge
        pushBeat(16'h0201, 2'b11, 1'b0);
        pushBeat(16'h0403, 2'b11, 1'b0);
        pushBeat(16'h0605, 2'b11, 1'b0);
        pushBeat(16'h0807, 2'b11, 1'b1);
        applyStimulus(7'd0, 8'd8);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checkOutput("first_valid_latency", bus.out_valid, (i == 4));
            if (i == 1) checkOutput("busy_after_start", busy, 1'b1);
            tick();
        end
        waitDrain("drain_cnt8", 50);
        checkOutput("busy_idle", busy, 1'b0);

        // wrap-around with odd count
        pushBeat(16'h807F, 2'b11, 1'b0);
        pushBeat(16'h0201, 2'b11, 1'b0);
        pushBeat(16'h0003, 2'b01, 1'b1);
        applyStimulus(7'd126, 8'd5);
        @(negedge clk);
        checkOutput("wrap_pair0", {bus.rom_addr_a, bus.rom_addr_b}, {7'd126, 7'd127});
        tick();
        @(negedge clk);
        checkOutput("wrap_pair1", {bus.rom_addr_a, bus.rom_addr_b}, {7'd0, 7'd1});
        tick();
        waitDrain("drain_wrap", 50);

        // count=0: done one cycle later, never busy, no beats
        base  = 7'd3;
        count = 8'd0;
        start = 1'b1;
        @(negedge clk);
        checkOutput("zero_done_early", done, 1'b0);
        tick();
        start = 1'b0;
        @(negedge clk);
        checkOutput("zero_done_pulse", done, 1'b1);
        checkOutput("zero_busy", busy, 1'b0);
        tick();
        @(negedge clk);
        checkOutput("zero_done_once", done, 1'b0);
        repeat (4) tick();

        // full ROM with ready toggling every cycle
        for (int k = 0; k < 64; k++) begin
            pushBeat({8'(2*k + 2), 8'(2*k + 1)}, 2'b11, (k == 63));
        end
        applyStimulus(7'd0, 8'd128);
        begin
            int n = 0;
            while ((sb.size() != 0 || busy) && n < 1000) begin
                bus.out_ready = ~bus.out_ready;
                tick();
                n++;
            end
            checkOutput("drain_toggle", (n < 1000), 1'b1);
        end
        bus.out_ready = 1'b1;
        repeat (2) tick();

        // start re-asserted during ISSUE is ignored
        pushBeat(16'h0201, 2'b11, 1'b0);
        pushBeat(16'h0403, 2'b11, 1'b0);
        pushBeat(16'h0605, 2'b11, 1'b1);
        applyStimulus(7'd0, 8'd6);
        base  = 7'd50;
        count = 8'd4;
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        waitDrain("drain_reassert", 50);
        repeat (8) tick();
        checkOutput("reassert_no_extra", sb.size(), 0);
        checkOutput("done_count", done_cnt, 5);

        // reset in DRAIN aborts silently, then a fresh command runs cleanly
        bus.out_ready = 1'b0;
        applyStimulus(7'd0, 8'd8);
        pushBeat(16'h0201, 2'b11, 1'b0);
        repeat (8) tick();
        checkOutput("stalled_busy", busy, 1'b1);
        sb.delete();
        rst_l = 1'b0;
        tick();
        rst_l = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy",  busy, 1'b0);
        checkOutput("abort_done",  done, 1'b0);
        checkOutput("abort_valid", bus.out_valid, 1'b0);
        checkOutput("abort_data",  bus.out_data, 16'h0);
        checkOutput("abort_keep_last", {bus.out_keep, bus.out_last}, 3'b000);
        checkOutput("abort_addr",  {bus.rom_addr_b, bus.rom_addr_a}, 14'h0);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        checkOutput("abort_no_done", done_cnt, 5);
        pushBeat(16'h0C0B, 2'b11, 1'b1);
        applyStimulus(7'd10, 8'd2);
        waitDrain("drain_after_reset", 50);
        repeat (4) tick();
        checkOutput("final_done_count", done_cnt, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_pair_streamer.md
# rom_pair_streamer

Read-sequencing stage placed directly upstream of the dual-port 128x8 coefficient ROM used by the SMVM datapath. On a start command it walks a contiguous, wrap-around address range, issuing two ROM reads per cycle (port A at even offset, port B at odd offset). It absorbs the ROM's fixed read latency and emits the data as a 16-bit valid/ready stream with last/keep markers. Credit-based issue guarantees no data loss under downstream backpressure.

## Interface
- ADDR_W, 7, ROM address width (128 entries)
- DATA_W, 8, ROM word width
- RD_LAT, 2, cycles from address edge to valid q (ROM with registered address and output)
- FIFO_DEPTH, 4, output buffer entries in beats; must be >= RD_LAT+2 for full throughput

- clk  in  1  single clock; also drives the ROM
- rst_l  in  1  synchronous, active-low reset
- start  in  1  command strobe, accepted only in IDLE
- base  in  ADDR_W  first ROM address of the range
- count  in  ADDR_W+1  entries to read, 0..128; values >128 clamp to 128
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of command
- rom_addr_a  out  ADDR_W  ROM port A address
- rom_addr_b  out  ADDR_W  ROM port B address
- rom_q_a  in  DATA_W  ROM port A data
- rom_q_b  in  DATA_W  ROM port B data
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- out_data  out  2*DATA_W  {entry odd, entry even}
- out_keep  out  2  bit0 = low byte valid, bit1 = high byte valid
- out_last  out  1  final beat of command

## Operation
- Reset (rst_l low at a clk edge): state IDLE, busy=0, done=0, rom_addr_a=rom_addr_b=0, out_valid=0, out_data=0, out_keep=0, out_last=0, FIFO flushed, in-flight reads discarded. Reset mid-command aborts with no done pulse.
- FSM: IDLE -> ISSUE on start with count>0; IDLE stays IDLE on start with count=0, pulsing done in the next cycle. ISSUE -> DRAIN after the final pair is issued. DRAIN -> IDLE when the beat with out_last is handshaked; done pulses in that same cycle the state returns to IDLE.
- start in ISSUE/DRAIN is ignored; base/count are latched only at acceptance.
- Issue: pair k drives rom_addr_a = (base+2k) mod 128, rom_addr_b = (base+2k+1) mod 128. Pairs = ceil(count/2). Addresses hold their last value when not issuing.
- Credit rule: issue allowed only if in_flight + fifo_occupancy < FIFO_DEPTH. in_flight is tracked by an RD_LAT-deep valid shift register carrying a last flag and an odd flag.
- Capture: when the valid pipe output is set, write {rom_q_b, rom_q_a} to FIFO. On the final pair of an odd count, the high byte is forced to 0 and keep=01; otherwise keep=11.
- out_* are the FIFO head; a beat pops when out_valid && out_ready. out_data must stay stable while out_valid && !out_ready.

## Timing
- Start accepted at edge E0; first pair addresses are valid after E0 (cycle 1); data captured at edge E0+1+RD_LAT; out_valid is high after that edge. First-beat latency = RD_LAT+2 edges after start.
- With out_ready held high and FIFO_DEPTH >= RD_LAT+2: one beat per cycle, no issue bubbles.
- Wrap: base=127 gives pair0 addresses 127,0.
- count=128: 64 beats, last beat keep=11. count=1: one beat, keep=01, last=1.
- Simultaneous FIFO push and pop at full occupancy is legal; occupancy is unchanged.

## Structure
- Package smvm_rom_pkg: ADDR_W/DATA_W defaults, state enum (IDLE, ISSUE, DRAIN), beat struct {data, keep, last}.
- Sub-module rom_rd_fifo: synchronous FIFO of beat structs, parameterised on depth, with occupancy output for credit logic, synchronous active-low reset.

## Test plan
- Bench ROM model mem[i]=i+1, RD_LAT=2. Command base=0, count=8, out_ready=1 -> beats 0x0201, 0x0403, 0x0605, 0x0807, keep=11, last on the 4th; first out_valid 4 edges after start; done with the last handshake.
- base=126, count=5 -> beats 0x807F, 0x0201, 0x0003 keep=01 last=1; rom_addr_b for pair0 = 127, pair1 addresses 0,1.
- count=0 -> no out_valid; done pulses 1 cycle after start; busy stays 0.
- base=0, count=128 with out_ready toggling 1-0 each cycle -> 64 beats in order, none dropped or duplicated, in_flight+occupancy never exceeds 4, out_data stable while stalled.
- start re-asserted with base=50 during ISSUE -> ignored; output matches the original command only.
- rst_l low for 1 cycle mid-DRAIN -> all outputs at reset values next cycle, no done; new command base=10, count=2 -> single beat 0x0C0B.
